// File: rtl/serial_rx_framer.sv
// Asynchronous serial receiver: synchronizes rx, frames start/data/parity/stop
// bits at bit centres, and hands each byte to a valid/ack consumer.
module serial_rx_framer #(
  parameter int unsigned CLK_TICKS_PER_BIT = 434,
  parameter int unsigned PARITY_MODE       = 1,
  parameter int unsigned STOP_BITS         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam logic [15:0] HALF_TICK = 16'(CLK_TICKS_PER_BIT / 2);
  localparam logic [15:0] LAST_TICK = 16'(CLK_TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t      state;
  logic [15:0] tick_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        parity_acc;
  logic        frame_acc;
  logic        rx_meta;
  logic        rx_sync;

  logic        bit_tick;
  logic        parity_bad;
  logic        completing;

  // Synchronizer presets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign bit_tick   = (tick_cnt == LAST_TICK);
  assign parity_bad = (PARITY_MODE == 2) ? ~(^{shift_reg, rx_sync}) : (^{shift_reg, rx_sync});
  assign completing = bit_tick &&
                      (((state == STOP1) && (STOP_BITS == 0)) || (state == STOP2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tick_cnt      <= 16'd0;
      bit_idx       <= 3'd0;
      shift_reg     <= 8'h00;
      parity_acc    <= 1'b0;
      frame_acc     <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            tick_cnt <= 16'd0;
            rx_busy  <= 1'b1;
          end
        end

        // Confirm the start bit at its centre; a glitch that is gone by then is ignored.
        START: begin
          if (tick_cnt == HALF_TICK) begin
            tick_cnt <= 16'd0;
            if (!rx_sync) begin
              state      <= DATA;
              bit_idx    <= 3'd0;
              parity_acc <= 1'b0;
              frame_acc  <= 1'b0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            tick_cnt  <= 16'd0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= (PARITY_MODE != 0) ? PARITY : STOP1;
            end
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        PARITY: begin
          if (bit_tick) begin
            tick_cnt   <= 16'd0;
            parity_acc <= parity_bad;
            state      <= STOP1;
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        STOP1: begin
          if (bit_tick) begin
            tick_cnt <= 16'd0;
            if (STOP_BITS == 1) begin
              frame_acc <= ~rx_sync;
              state     <= STOP2;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        STOP2: begin
          if (bit_tick) begin
            tick_cnt <= 16'd0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= 16'd0;
          rx_busy  <= 1'b0;
        end
      endcase

      // An ack arriving with a completed frame frees the holding register for it.
      if (completing) begin
        if (!rx_valid || rx_ack) begin
          rx_data       <= shift_reg;
          rx_parity_err <= parity_acc;
          rx_frame_err  <= frame_acc | ~rx_sync;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_framer.sv
// Directed bench for serial_rx_framer: an even-parity and an odd-parity
// receiver listen to the same line and acknowledge strobe.
module tb_serial_rx_framer;

  localparam int TICKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;

  logic [7:0] e_data;
  logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;
  logic [7:0] o_data;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;

  serial_rx_framer #(.CLK_TICKS_PER_BIT(TICKS), .PARITY_MODE(1), .STOP_BITS(0)) dut_even (
    .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
    .rx_data(e_data), .rx_valid(e_valid), .rx_parity_err(e_perr),
    .rx_frame_err(e_ferr), .rx_overrun(e_ovr), .rx_busy(e_busy)
  );

  serial_rx_framer #(.CLK_TICKS_PER_BIT(TICKS), .PARITY_MODE(2), .STOP_BITS(0)) dut_odd (
    .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
    .rx_data(o_data), .rx_valid(o_valid), .rx_parity_err(o_perr),
    .rx_frame_err(o_ferr), .rx_overrun(o_ovr), .rx_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (e_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = e_valid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Start bit, 8 data bits LSB first, parity, one stop; each bit lasts TICKS clocks.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start_cyc = cyc;
      rx = bits[i];
      repeat (TICKS - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", e_valid); end
    tests_run++; if (e_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 00", e_data); end
    tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_perr: got %b expected 0", e_perr); end
    tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ferr: got %b expected 0", e_ferr); end
    tests_run++; if (e_ovr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovr: got %b expected 0", e_ovr); end
    tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", e_busy); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_busy: got %b expected 0", e_busy); end
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_valid: got %b expected 0", e_valid); end
  endtask

  task automatic test_basic_frame();
    rise_cyc = -1;
    send_frame(8'h41, 1'b0, 1'b1);
    idle(4);
    // 2 sync + 1 to START + 9 to start centre + 10 bit periods of 16
    tests_run++; if (rise_cyc - start_cyc !== 172) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0d expected 172", rise_cyc - start_cyc); end
    tests_run++; if (e_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid: got %b expected 1", e_valid); end
    tests_run++; if (e_data !== 8'h41) begin tests_failed++; $display("[TB] FAIL basic_data: got %h expected 41", e_data); end
    tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_perr: got %b expected 0", e_perr); end
    tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_ferr: got %b expected 0", e_ferr); end
    tests_run++; if (o_perr !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_odd_perr: got %b expected 1", o_perr); end
    ack_pulse();
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_ack_valid: got %b expected 0", e_valid); end
    tests_run++; if (e_data !== 8'h41) begin tests_failed++; $display("[TB] FAIL basic_ack_hold: got %h expected 41", e_data); end
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_ack_odd_valid: got %b expected 0", o_valid); end
  endtask

  task automatic test_parity();
    send_frame(8'h41, 1'b1, 1'b1);
    idle(4);
    tests_run++; if (e_data !== 8'h41) begin tests_failed++; $display("[TB] FAIL parity_data: got %h expected 41", e_data); end
    tests_run++; if (e_perr !== 1'b1) begin tests_failed++; $display("[TB] FAIL parity_even_err: got %b expected 1", e_perr); end
    tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_ferr: got %b expected 0", e_ferr); end
    tests_run++; if (o_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_odd_err: got %b expected 0", o_perr); end
    tests_run++; if (o_data !== 8'h41) begin tests_failed++; $display("[TB] FAIL parity_odd_data: got %h expected 41", o_data); end
    ack_pulse();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0);
    idle(40);
    tests_run++; if (e_data !== 8'h55) begin tests_failed++; $display("[TB] FAIL ferr_data: got %h expected 55", e_data); end
    tests_run++; if (e_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ferr_valid: got %b expected 1", e_valid); end
    tests_run++; if (e_ferr !== 1'b1) begin tests_failed++; $display("[TB] FAIL ferr_flag: got %b expected 1", e_ferr); end
    tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL ferr_perr: got %b expected 0", e_perr); end
    tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ferr_busy: got %b expected 0", e_busy); end
    ack_pulse();
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(4);
    tests_run++; if (e_data !== 8'hAA) begin tests_failed++; $display("[TB] FAIL ferr_next_data: got %h expected aa", e_data); end
    tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL ferr_next_flag: got %b expected 0", e_ferr); end
    tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL ferr_next_perr: got %b expected 0", e_perr); end
    ack_pulse();
  endtask

  task automatic test_false_start();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    tests_run++; if (e_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL false_busy_high: got %b expected 1", e_busy); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL false_busy_low: got %b expected 0", e_busy); end
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL false_valid: got %b expected 0", e_valid); end
    idle(40);
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL false_valid_late: got %b expected 0", e_valid); end
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    idle(4);
    tests_run++; if (e_data !== 8'h01) begin tests_failed++; $display("[TB] FAIL ovr_data: got %h expected 01", e_data); end
    tests_run++; if (e_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_valid: got %b expected 1", e_valid); end
    tests_run++; if (e_ovr !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_flag: got %b expected 1", e_ovr); end
    ack_pulse();
    tests_run++; if (e_ovr !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_sticky: got %b expected 1", e_ovr); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++; if (e_ovr !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ovr_cleared: got %b expected 0", e_ovr); end
    send_frame(8'h01, 1'b1, 1'b1);
    fork
      send_frame(8'h02, 1'b1, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (171) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    idle(4);
    tests_run++; if (e_data !== 8'h02) begin tests_failed++; $display("[TB] FAIL b2b_data: got %h expected 02", e_data); end
    tests_run++; if (e_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid: got %b expected 1", e_valid); end
    tests_run++; if (e_ovr !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ovr: got %b expected 0", e_ovr); end
    ack_pulse();
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'h7E, 1'b0, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (69) @(posedge clk);
        @(negedge clk);
        tests_run++; if (e_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_busy_before: got %b expected 1", e_busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", e_busy); end
        tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", e_valid); end
        tests_run++; if (e_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL mid_rst_data: got %h expected 00", e_data); end
        tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_perr: got %b expected 0", e_perr); end
        tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ferr: got %b expected 0", e_ferr); end
        tests_run++; if (e_ovr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ovr: got %b expected 0", e_ovr); end
      end
    join
    @(posedge clk);
    #1 rst = 1'b1;
    idle(10);
    tests_run++; if (e_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_after_valid: got %b expected 0", e_valid); end
    tests_run++; if (e_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_after_busy: got %b expected 0", e_busy); end
    send_frame(8'h33, 1'b0, 1'b1);
    idle(4);
    tests_run++; if (e_data !== 8'h33) begin tests_failed++; $display("[TB] FAIL mid_next_data: got %h expected 33", e_data); end
    tests_run++; if (e_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_next_valid: got %b expected 1", e_valid); end
    tests_run++; if (e_perr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_next_perr: got %b expected 0", e_perr); end
    tests_run++; if (e_ferr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_next_ferr: got %b expected 0", e_ferr); end
    tests_run++; if (e_ovr !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_next_ovr: got %b expected 0", e_ovr); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
